// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pkg
//  Purpose  : Shared types for the two-input round-robin stream arbiter.
//             src_e names the two sources and RESET_GRANT seeds the
//             last-grant register so that A wins the first tie.
//  Revision : 1.0  initial release
// ============================================================================
package mux_pkg;

    typedef enum logic {
        SRC_B = 1'b0,
        SRC_A = 1'b1
    } src_e;

    localparam src_e RESET_GRANT = SRC_B;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux2to1.sv
`default_nettype none
// ============================================================================
//  Module   : mux2to1
//  Purpose  : N-bit two-way multiplexer. sel=1 passes a, sel=0 passes b.
//  Revision : 1.0  initial release
// ============================================================================
module mux2to1 #(
    parameter int N = 4
) (
    input  logic         sel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    // Pure select; no state.
    assign y = sel ? a : b;

endmodule : mux2to1
`default_nettype wire

// File: rtl/rr_arb2_stream.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2_stream
//  Purpose  : Two-source round-robin arbiter feeding a single-entry output
//             register through mux2to1. One word per cycle, back-pressured
//             by y_ready, ready never depends on data.
//  Config   : FIXED_PRIO_EN - when defined, A always wins a tie (last grant
//             is still tracked so the port list and state are identical).
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2_stream
    import mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    input  logic [N-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [N-1:0] b_data,
    output logic         b_ready,
    output logic         sel,
    output logic         y_valid,
    output logic [N-1:0] y_data,
    input  logic         y_ready
);

    src_e         r_last_grant;
    src_e         w_grant;
    logic         w_load;
    logic         w_xfer;
    logic [N-1:0] w_mux_y;
    logic         r_y_valid;
    logic [N-1:0] r_y_data;

    // The output slot can take a word when it is empty or being drained now.
    assign w_load = !r_y_valid || y_ready;

    // Grant selection: a lone requester wins; a tie goes to the other side
    // of the last winner (or always to A in the fixed-priority build); with
    // no requester the grant simply reflects the last winner.
    always_comb begin
        w_grant = r_last_grant;
        if (a_valid && b_valid) begin
`ifdef FIXED_PRIO_EN
            w_grant = SRC_A;
`else
            w_grant = (r_last_grant == SRC_A) ? SRC_B : SRC_A;
`endif
        end else if (a_valid) begin
            w_grant = SRC_A;
        end else if (b_valid) begin
            w_grant = SRC_B;
        end
    end

    // Readies are held low during reset so nothing is consumed that the
    // reset would then drop silently on the source side.
    assign sel     = (w_grant == SRC_A);
    assign a_ready = !rst && w_load && (w_grant == SRC_A);
    assign b_ready = !rst && w_load && (w_grant == SRC_B);
    assign w_xfer  = (a_valid && a_ready) || (b_valid && b_ready);

    mux2to1 #(
        .N (N)
    ) u_mux (
        .sel (sel),
        .a   (a_data),
        .b   (b_data),
        .y   (w_mux_y)
    );

    // Output register and last-grant state: load on a handshake, empty
    // when drained with nothing new, otherwise hold (covers the stall).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_valid    <= 1'b0;
            r_y_data     <= '0;
            r_last_grant <= RESET_GRANT;
        end else if (w_xfer) begin
            r_y_valid    <= 1'b1;
            r_y_data     <= w_mux_y;
            r_last_grant <= w_grant;
        end else if (y_ready) begin
            r_y_valid    <= 1'b0;
        end
    end

    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;

endmodule : rr_arb2_stream
`default_nettype wire

// File: tb/tb_rr_arb2_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arb2_stream
//  Purpose  : Scoreboard bench for rr_arb2_stream. A transaction-level model
//             (slot occupied flag, last winner, expected-word queue) predicts
//             readies and the output stream; a monitor pops and compares.
//  Config   : FIXED_PRIO_EN selects the fixed-priority expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arb2_stream;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, y_ready;
    logic [N-1:0] a_data, b_data;
    logic         a_ready, b_ready, sel, y_valid;
    logic [N-1:0] y_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [N-1:0] exp_q[$];
    bit           m_full;
    bit           m_last_a;
    bit           rst_at_edge = 1'b0;

    always #10 clk = ~clk;

    rr_arb2_stream #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .sel     (sel),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_at_edge <= rst;

    // Monitor: output side of the scoreboard.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            check("reset_y_valid", {31'd0, y_valid}, 32'd0);
            check("reset_y_data", {28'd0, y_data}, 32'd0);
        end else begin
            check("y_valid_vs_queue", {31'd0, y_valid}, {31'd0, exp_q.size() != 0});
            if (y_valid && y_ready && exp_q.size() != 0) begin
                check("y_data", {28'd0, y_data}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    // Drive one cycle of inputs, then predict and check the handshake.
    task automatic step(input logic r, input logic av, input logic [N-1:0] ad,
                        input logic bv, input logic [N-1:0] bd, input logic yr);
        bit load, win_a, any, exp_ar, exp_br;
        @(posedge clk);
        #1;
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
        @(negedge clk);
        #1;
        check("never_both_ready", {31'd0, a_ready && b_ready}, 32'd0);
        if (r) begin
            check("rst_a_ready", {31'd0, a_ready}, 32'd0);
            check("rst_b_ready", {31'd0, b_ready}, 32'd0);
            exp_q.delete();
            m_full   = 1'b0;
            m_last_a = 1'b0;
        end else begin
            load = !m_full || yr;
            any  = av || bv;
            if (av && bv) begin
`ifdef FIXED_PRIO_EN
                win_a = 1'b1;
`else
                win_a = !m_last_a;
`endif
            end else begin
                win_a = any ? av : m_last_a;
            end
            exp_ar = load && win_a;
            exp_br = load && !win_a;
            check("sel", {31'd0, sel}, {31'd0, win_a});
            check("a_ready", {31'd0, a_ready}, {31'd0, exp_ar});
            check("b_ready", {31'd0, b_ready}, {31'd0, exp_br});
            if (load && any) begin
                exp_q.push_back(win_a ? ad : bd);
                m_full   = 1'b1;
                m_last_a = win_a;
            end else if (yr) begin
                m_full = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b0;
        a_data = '0; b_data = '0;
        m_full = 1'b0; m_last_a = 1'b0;

        // Reset with both sources requesting.
        step(1, 1, 4'h1, 1, 4'h2, 1);
        step(1, 1, 4'h1, 1, 4'h2, 1);
        // Lone A.
        step(0, 1, 4'hA, 0, 4'h0, 1);
        step(0, 0, 4'h0, 0, 4'h0, 1);
        // Tie for four cycles: alternation (or A only in fixed-priority).
        for (int i = 0; i < 4; i++) step(0, 1, 4'h3, 1, 4'hC, 1);
        step(0, 0, 4'h0, 0, 4'h0, 1);
        // Stall with a word of 5 held for three cycles, then release.
        step(0, 1, 4'h5, 0, 4'h0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 4'h6, 1, 4'h9, 0);
        step(0, 1, 4'h6, 1, 4'h9, 1);
        step(0, 1, 4'h7, 1, 4'h8, 0);
        // Reset in mid-stream, then a tie must go to A.
        step(1, 1, 4'h7, 1, 4'h8, 0);
        step(0, 1, 4'hE, 1, 4'hD, 1);
        step(0, 1, 4'hE, 1, 4'hD, 1);
        step(0, 0, 4'h0, 0, 4'h0, 1);

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7), N'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 6), N'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 7));
        end

        // Drain and confirm nothing was lost.
        for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 0, 4'h0, 1);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_rr_arb2_stream
`default_nettype wire
